// File: rtl/multi_alarm_controller.sv
// multi_alarm_controller: NUM_ALARMS independent alarm channels fed by the
// 24-hour time and a one-second tick. Each channel rings for RING_SECS ticks
// unless acknowledged, and can optionally be snoozed for SNOOZE_MIN minutes.
// Optional feature macro: MULTI_ALARM_SNOOZE_EN (snooze state and targets).

// Per-channel state machine: stored alarm time, enable, ring countdown and
// (when built) the snooze target.
module alarm_channel #(
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tick,
  input  logic [7:0] i_cur_hour,
  input  logic [7:0] i_cur_min,
  input  logic [7:0] i_cur_sec,
  input  logic       i_wr_hit,
  input  logic [7:0] i_wr_hour,
  input  logic [7:0] i_wr_min,
  input  logic [7:0] i_wr_sec,
  input  logic       i_wr_enable,
  input  logic       i_ack,
`ifdef MULTI_ALARM_SNOOZE_EN
  input  logic       i_snooze,
`endif
  output logic       o_ringing
);

`ifdef MULTI_ALARM_SNOOZE_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RING = 2'd1, S_SNZ = 2'd2} state_t;
`else
  typedef enum logic {S_IDLE = 1'b0, S_RING = 1'b1} state_t;
`endif

  state_t     r_state;
  logic [7:0] r_hour, r_min, r_sec;
  logic       r_en;
  logic [7:0] r_cnt;
  logic       w_alarm_hit;

  // Out-of-range stored values can never equal a valid current time.
  assign w_alarm_hit = r_en && (i_cur_hour == r_hour) &&
                       (i_cur_min == r_min) && (i_cur_sec == r_sec);

`ifdef MULTI_ALARM_SNOOZE_EN
  logic [7:0] r_snz_hour, r_snz_min, r_snz_sec;
  logic [8:0] w_min_sum;
  logic [8:0] w_min_wrapped;
  logic       w_min_wrap;
  logic [7:0] w_hour_inc;
  logic [7:0] w_tgt_hour, w_tgt_min;
  logic       w_snz_hit;

  // Snooze target = now + SNOOZE_MIN minutes, seconds kept, midnight wraps.
  assign w_min_sum     = {1'b0, i_cur_min} + 9'(SNOOZE_MIN);
  assign w_min_wrap    = (w_min_sum >= 9'd60);
  assign w_min_wrapped = w_min_sum - 9'd60;
  assign w_hour_inc    = i_cur_hour + 8'd1;
  assign w_tgt_min     = w_min_wrap ? w_min_wrapped[7:0] : w_min_sum[7:0];
  assign w_tgt_hour    = !w_min_wrap ? i_cur_hour :
                         (w_hour_inc == 8'd24) ? 8'd0 : w_hour_inc;
  assign w_snz_hit     = (i_cur_hour == r_snz_hour) && (i_cur_min == r_snz_min) &&
                         (i_cur_sec == r_snz_sec);
`endif

  // Channel FSM: reset > write > ack > snooze > tick.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_hour  <= '0;
      r_min   <= '0;
      r_sec   <= '0;
      r_en    <= 1'b0;
      r_cnt   <= '0;
`ifdef MULTI_ALARM_SNOOZE_EN
      r_snz_hour <= '0;
      r_snz_min  <= '0;
      r_snz_sec  <= '0;
`endif
    end else if (i_wr_hit) begin
      r_hour  <= i_wr_hour;
      r_min   <= i_wr_min;
      r_sec   <= i_wr_sec;
      r_en    <= i_wr_enable;
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else if (i_ack && (r_state != S_IDLE)) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
`ifdef MULTI_ALARM_SNOOZE_EN
    end else if (i_snooze && (r_state == S_RING)) begin
      r_state    <= S_SNZ;
      r_cnt      <= '0;
      r_snz_hour <= w_tgt_hour;
      r_snz_min  <= w_tgt_min;
      r_snz_sec  <= i_cur_sec;
`endif
    end else if (i_tick) begin
      case (r_state)
        S_IDLE: begin
          if (w_alarm_hit) begin
            r_state <= S_RING;
            r_cnt   <= 8'(RING_SECS);
          end
        end
        S_RING: begin
          // A tick on the last count ends the ring; re-matches are ignored.
          if (r_cnt == 8'd1) r_state <= S_IDLE;
          r_cnt <= r_cnt - 8'd1;
        end
`ifdef MULTI_ALARM_SNOOZE_EN
        S_SNZ: begin
          if (w_snz_hit) begin
            r_state <= S_RING;
            r_cnt   <= 8'(RING_SECS);
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ringing = (r_state == S_RING);

endmodule

module multi_alarm_controller #(
  parameter int NUM_ALARMS = 4,
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int IDX_W      = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_tick,
  input  logic [7:0]            i_cur_hour,
  input  logic [7:0]            i_cur_min,
  input  logic [7:0]            i_cur_sec,
  input  logic                  i_wr_en,
  input  logic [IDX_W-1:0]      i_wr_idx,
  input  logic [7:0]            i_wr_hour,
  input  logic [7:0]            i_wr_min,
  input  logic [7:0]            i_wr_sec,
  input  logic                  i_wr_enable,
  input  logic                  i_ack,
  input  logic                  i_snooze,
  output logic [NUM_ALARMS-1:0] o_alarm_active,
  output logic                  o_alarm_sound,
  output logic [IDX_W-1:0]      o_ring_idx
);

  logic [NUM_ALARMS-1:0] w_wr_hit;
  logic [IDX_W-1:0]      w_ring_idx;

`ifndef MULTI_ALARM_SNOOZE_EN
  logic w_unused_snooze;
  assign w_unused_snooze = i_snooze;
`endif

  for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_ch
    // Indices >= NUM_ALARMS never hit any channel.
    assign w_wr_hit[g] = i_wr_en && (i_wr_idx == IDX_W'(g));

    alarm_channel #(
      .RING_SECS  (RING_SECS),
      .SNOOZE_MIN (SNOOZE_MIN)
    ) u_ch (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_tick      (i_tick),
      .i_cur_hour  (i_cur_hour),
      .i_cur_min   (i_cur_min),
      .i_cur_sec   (i_cur_sec),
      .i_wr_hit    (w_wr_hit[g]),
      .i_wr_hour   (i_wr_hour),
      .i_wr_min    (i_wr_min),
      .i_wr_sec    (i_wr_sec),
      .i_wr_enable (i_wr_enable),
      .i_ack       (i_ack),
`ifdef MULTI_ALARM_SNOOZE_EN
      .i_snooze    (i_snooze),
`endif
      .o_ringing   (o_alarm_active[g])
    );
  end

  // Lowest ringing index wins; decoded purely from channel state registers.
  always_comb begin
    w_ring_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (o_alarm_active[i]) w_ring_idx = IDX_W'(i);
    end
  end

  assign o_ring_idx    = w_ring_idx;
  assign o_alarm_sound = |o_alarm_active;

endmodule
